// File: rtl/pe_stream_ctrl.sv
// pe_stream_ctrl
//   Buffers one block of IN_DEPTH input vectors taken over a valid/ready
//   handshake. It then replays the block to the selected processing element
//   OUT_DEPTH times. Before each pass it requests a fresh weight set, and after
//   each pass it captures the PE result into an output buffer that the host can
//   read back at any time.
//
//   Optional build macro: PE_PERF_CNT_EN adds a 32-bit busy-cycle counter.
//
// Ports
//   clk, rst          clock, asynchronous active-low reset
//   en                global stall (0 = everything holds)
//   mode, start       job request; mode 01=int 10=ap 11=fp, 00 flags err
//   din_valid/ready   input vector handshake, din = vector
//   wt_req, wt_ack    weight-set handshake before every pass
//   pe_ce             one-hot PE clock enable {fp,ap,int}
//   pe_en, pe_data    registered vector stream to the PE
//   pe_clr            one-cycle accumulator clear at capture
//   pe_result         muxed PE result
//   rd_en, rd_addr    host readback request, rd_data one clock later
//   busy, done, err   status; done is a one-cycle pulse, err is sticky
//   perf_cycles       (PE_PERF_CNT_EN only) saturating busy-cycle count
module pe_stream_ctrl #(
   parameter int DIN_W     = 256,
   parameter int DOUT_W    = 188,
   parameter int IN_DEPTH  = 64,
   parameter int OUT_DEPTH = 16,
   parameter int PE_LAT    = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic [1:0]                   mode,
   input  logic                         start,
   input  logic                         din_valid,
   output logic                         din_ready,
   input  logic [DIN_W-1:0]             din,
   output logic                         wt_req,
   input  logic                         wt_ack,
   output logic [2:0]                   pe_ce,
   output logic                         pe_en,
   output logic [DIN_W-1:0]             pe_data,
   output logic                         pe_clr,
   input  logic [DOUT_W-1:0]            pe_result,
   input  logic [$clog2(OUT_DEPTH)-1:0] rd_addr,
   input  logic                         rd_en,
   output logic [DOUT_W-1:0]            rd_data,
   output logic                         busy,
   output logic                         done,
`ifdef PE_PERF_CNT_EN
   output logic [31:0]                  perf_cycles,
`endif
   output logic                         err
);

   localparam int IW = $clog2(IN_DEPTH);
   localparam int KW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int LW = $clog2(PE_LAT + 1);
   localparam logic [IW-1:0] I_LAST = IW'(IN_DEPTH - 1);
   localparam logic [KW-1:0] K_LAST = KW'(OUT_DEPTH - 1);
   localparam logic [LW-1:0] W_LAST = LW'(PE_LAT - 1);

   typedef enum logic [2:0] {
      IDLE, LOAD, WT, RUN, WAIT, CAP, DONE
   } state_t;

   state_t            state, nxt;
   logic [1:0]        mode_q;
   logic [IW-1:0]     i_cnt, j_cnt, j_inc;
   logic [LW-1:0]     w_cnt;
   logic [KW-1:0]     k_cnt;
   logic [DIN_W-1:0]  inbuf  [IN_DEPTH];
   logic [DOUT_W-1:0] outbuf [OUT_DEPTH];

   assign j_inc = j_cnt + 1'b1;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nxt;
   end

   // Next state and state-decoded outputs. Since every output depends only on
   // the state register, freezing the state with en=0 also freezes the
   // handshakes and stretches a pending done pulse.
   always_comb begin
      nxt       = state;
      din_ready = 1'b0;
      wt_req    = 1'b0;
      pe_en     = 1'b0;
      pe_clr    = 1'b0;
      done      = 1'b0;
      busy      = (state != IDLE);
      case (state)
         IDLE: if (start && mode != 2'b00) nxt = LOAD;
         LOAD: begin
            din_ready = 1'b1;
            if (din_valid && i_cnt == I_LAST) nxt = WT;
         end
         WT: begin
            wt_req = 1'b1;
            if (wt_ack) nxt = RUN;
         end
         RUN: begin
            pe_en = 1'b1;
            if (j_cnt == I_LAST) nxt = WAIT;
         end
         WAIT: if (w_cnt == W_LAST) nxt = CAP;
         CAP: begin
            pe_clr = 1'b1;
            nxt    = (k_cnt == K_LAST) ? DONE : WT;
         end
         DONE: begin
            done = 1'b1;
            nxt  = IDLE;
         end
         default: nxt = IDLE;
      endcase
      if (!en) nxt = state;
   end

   always_comb begin
      pe_ce = 3'b000;
      if (state != IDLE) begin
         case (mode_q)
            2'b01:   pe_ce = 3'b001;
            2'b10:   pe_ce = 3'b010;
            2'b11:   pe_ce = 3'b100;
            default: pe_ce = 3'b000;
         endcase
      end
   end

   // Counters, latched mode, error flag and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mode_q  <= 2'b00;
         err     <= 1'b0;
         i_cnt   <= '0;
         j_cnt   <= '0;
         w_cnt   <= '0;
         k_cnt   <= '0;
         pe_data <= '0;
         rd_data <= '0;
      end else if (en) begin
         // The read sees outbuf before a same-cycle capture lands
         if (rd_en) rd_data <= outbuf[rd_addr];
         case (state)
            IDLE: if (start) begin
               if (mode == 2'b00) err <= 1'b1;
               else begin
                  err    <= 1'b0;
                  mode_q <= mode;
               end
            end
            LOAD: if (din_valid) i_cnt <= (i_cnt == I_LAST) ? '0 : i_cnt + 1'b1;
            WT: if (wt_ack) begin
               // Preload the first vector so pe_en and pe_data rise together
               j_cnt   <= '0;
               pe_data <= inbuf[0];
            end
            RUN: begin
               if (j_cnt == I_LAST) j_cnt <= '0;   // pe_data holds through WAIT
               else begin
                  j_cnt   <= j_inc;
                  pe_data <= inbuf[j_inc];
               end
            end
            WAIT: w_cnt <= (w_cnt == W_LAST) ? '0 : w_cnt + 1'b1;
            CAP:  k_cnt <= (k_cnt == K_LAST) ? '0 : k_cnt + 1'b1;
            default: ;
         endcase
      end
   end

   // Buffer storage. It has no reset because the contents after reset are
   // don't-care.
   always_ff @(posedge clk) begin
      if (en && state == LOAD && din_valid) inbuf[i_cnt]  <= din;
      if (en && state == CAP)               outbuf[k_cnt] <= pe_result;
   end

`ifdef PE_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) perf_cycles <= '0;
      else if (en) begin
         if (state == IDLE && start && mode != 2'b00) perf_cycles <= '0;
         else if (busy && perf_cycles != '1)          perf_cycles <= perf_cycles + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pe_stream_ctrl.sv
// Self-checking bench for pe_stream_ctrl. A small PE model accumulates
// pe_data plus the current weight set. Its result becomes valid PE_LAT-1
// cycles after the last pe_en and shows random junk before that. Expected
// readback values come from plain sums over the stimulus vectors and weights.
module tb_pe_stream_ctrl;
   localparam int DIN_W = 256, DOUT_W = 188, IN_DEPTH = 4, OUT_DEPTH = 2, PE_LAT = 2;
   localparam int AW = $clog2(OUT_DEPTH);

   logic clk = 1'b0, rst = 1'b0, en = 1'b1, start = 1'b0;
   logic din_valid = 1'b0, wt_ack = 1'b0, rd_en = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [DIN_W-1:0] din = '0;
   logic [AW-1:0] rd_addr = '0;
   logic din_ready, wt_req, pe_en, pe_clr, busy, done, err;
   logic [2:0] pe_ce;
   logic [DIN_W-1:0] pe_data;
   logic [DOUT_W-1:0] pe_result, rd_data;
`ifdef PE_PERF_CNT_EN
   logic [31:0] perf_cycles;
`endif

   int vecs = 0, errs = 0;

   pe_stream_ctrl #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .IN_DEPTH(IN_DEPTH),
                    .OUT_DEPTH(OUT_DEPTH), .PE_LAT(PE_LAT)) dut (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .start(start),
      .din_valid(din_valid), .din_ready(din_ready), .din(din),
      .wt_req(wt_req), .wt_ack(wt_ack), .pe_ce(pe_ce), .pe_en(pe_en),
      .pe_data(pe_data), .pe_clr(pe_clr), .pe_result(pe_result),
      .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
      .busy(busy), .done(done),
`ifdef PE_PERF_CNT_EN
      .perf_cycles(perf_cycles),
`endif
      .err(err));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit, required finish");
      $fatal(1);
   end

   // ---------------- stimulus state and reference model ----------------
   logic [DIN_W-1:0]  vin     [IN_DEPTH];
   logic [DOUT_W-1:0] pass_w  [OUT_DEPTH];
   logic [DOUT_W-1:0] exp_out [OUT_DEPTH];
   logic [DOUT_W-1:0] weight = '0;
   bit exp_valid = 1'b0;

   function automatic logic [DIN_W-1:0] rnd_vec();
      logic [DIN_W-1:0] r = '0;
      for (int i = 0; i < DIN_W / 32; i++) r = {r[DIN_W-33:0], $urandom};
      return r;
   endfunction

   function automatic logic [DOUT_W-1:0] pass_sum(input logic [DOUT_W-1:0] w);
      logic [DOUT_W-1:0] s = '0;
      for (int i = 0; i < IN_DEPTH; i++) s = s + DOUT_W'(vin[i]) + w;
      return s;
   endfunction

   // ---------------- PE model ----------------
   logic [DOUT_W-1:0] acc = '0, junk = '1;
   int since = 100;
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc   <= '0;
         since <= 100;
      end else begin
         junk <= DOUT_W'(rnd_vec());
         if (pe_en && en) begin
            acc   <= acc + DOUT_W'(pe_data) + weight;
            since <= 0;
         end else begin
            if (pe_clr && en) acc <= '0;
            if (since < 100) since <= since + 1;
         end
      end
   end
   assign pe_result = (since >= PE_LAT - 1) ? acc : junk;

   // ---------------- observation monitor ----------------
   logic [DIN_W-1:0] seen_q[$];
   int gap_q[$];
   int cyc = 0, last_en_cyc = 0, clr_cnt = 0, done_cnt = 0;
   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst && en && pe_en) begin
         seen_q.push_back(pe_data);
         last_en_cyc = cyc;
      end
      if (rst && en && pe_clr) begin
         clr_cnt = clr_cnt + 1;
         gap_q.push_back(cyc - last_en_cyc);
      end
      if (rst && en && done) done_cnt = done_cnt + 1;
   end

   // ---------------- stimulus drivers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [1:0] m);
      mode  = m;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic load_block(input bit gappy, output bit ok);
      bit pat[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      int idx = 0, t = 0;
      bit hs;
      ok = 1'b1;
      while (idx < IN_DEPTH) begin
         din_valid = gappy ? pat[t % 6] : 1'b1;
         din       = din_valid ? vin[idx] : rnd_vec();
         hs        = din_valid && din_ready;
         step();
         if (hs) idx++;
         t++;
         if (t > 60) begin
            ok = 1'b0;
            break;
         end
      end
      din_valid = 1'b0;
   endtask

   task automatic wait_wt(output bit ok);
      int t = 0;
      while (wt_req !== 1'b1 && t < 100) begin
         step();
         t++;
      end
      ok = (wt_req === 1'b1);
   endtask

   // Runs every pass from the first WT onwards, then waits for done and
   // updates the expected output buffer
   task automatic finish_job(input int ack_dly, input int stall, output bit ok);
      bit ok1;
      int t;
      ok = 1'b1;
      for (int p = 0; p < OUT_DEPTH; p++) begin
         wait_wt(ok1);
         if (!ok1) begin
            ok = 1'b0;
            return;
         end
         repeat (ack_dly) step();
         weight    = DOUT_W'(rnd_vec());
         pass_w[p] = weight;
         wt_ack    = 1'b1;
         step();
         wt_ack    = 1'b0;
         if (stall > 0 && p == 0) begin
            t = 0;
            while (pe_en === 1'b1 && t < 50) begin
               step();
               t++;
            end
            en = 1'b0;
            repeat (stall) step();
            en = 1'b1;
         end
      end
      t = 0;
      while (done !== 1'b1 && t < 200) begin
         step();
         t++;
      end
      if (done !== 1'b1) ok = 1'b0;
      step();
      for (int p = 0; p < OUT_DEPTH; p++) exp_out[p] = pass_sum(pass_w[p]);
      exp_valid = ok;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b0;
      repeat (2) step();
      vecs++;
      if ({din_ready, wt_req, pe_ce, pe_en, pe_clr, busy, done, err} !== 10'd0) begin
         errs++;
         $display("FAIL reset_ctrl: got %b required 0",
                  {din_ready, wt_req, pe_ce, pe_en, pe_clr, busy, done, err});
      end
      vecs++;
      if (pe_data !== '0) begin errs++; $display("FAIL reset_pe_data: got %h required 0", pe_data); end
      vecs++;
      if (rd_data !== '0) begin errs++; $display("FAIL reset_rd_data: got %h required 0", rd_data); end
      rst = 1'b1;
      step();
   endtask

   task automatic test_basic_job();
      bit ok, ok1;
      int s0 = seen_q.size(), g0 = gap_q.size(), c0 = clr_cnt, d0 = done_cnt;
      for (int i = 0; i < IN_DEPTH; i++) vin[i] = DIN_W'(i + 1);
      start_job(2'b01);
      vecs++;
      if (pe_ce !== 3'b001) begin errs++; $display("FAIL basic_pe_ce: got %b required 001", pe_ce); end
      load_block(1'b0, ok);
      finish_job(1, 0, ok1);
      vecs++;
      if (!(ok && ok1)) begin errs++; $display("FAIL basic_timeout: got stuck required job end"); end
      vecs++;
      if (seen_q.size() - s0 !== IN_DEPTH * OUT_DEPTH) begin
         errs++;
         $display("FAIL basic_pe_en_count: got %0d required %0d", seen_q.size() - s0, IN_DEPTH * OUT_DEPTH);
      end
      for (int i = 0; i < IN_DEPTH * OUT_DEPTH && s0 + i < seen_q.size(); i++) begin
         vecs++;
         if (seen_q[s0+i] !== vin[i % IN_DEPTH]) begin
            errs++;
            $display("FAIL basic_pe_data[%0d]: got %0h required %0h", i, seen_q[s0+i], vin[i % IN_DEPTH]);
         end
      end
      vecs++;
      if (clr_cnt - c0 !== OUT_DEPTH) begin errs++; $display("FAIL basic_clr_count: got %0d required %0d", clr_cnt - c0, OUT_DEPTH); end
      vecs++;
      if (done_cnt - d0 !== 1) begin errs++; $display("FAIL basic_done_count: got %0d required 1", done_cnt - d0); end
      for (int i = g0; i < gap_q.size(); i++) begin
         vecs++;
         if (gap_q[i] !== PE_LAT + 1) begin errs++; $display("FAIL basic_cap_gap: got %0d required %0d", gap_q[i], PE_LAT + 1); end
      end
      vecs++;
      if (busy !== 1'b0) begin errs++; $display("FAIL basic_busy_end: got %b required 0", busy); end
   endtask

   task automatic test_readback();
      int a;
      logic [DOUT_W-1:0] held;
      for (int n = 0; n < 6; n++) begin
         a       = (n < OUT_DEPTH) ? n : int'($urandom_range(0, OUT_DEPTH - 1));
         rd_addr = AW'(a);
         rd_en   = 1'b1;
         step();
         rd_en   = 1'b0;
         vecs++;
         if (rd_data !== exp_out[a]) begin
            errs++;
            $display("FAIL readback[%0d]: got %h required %h", a, rd_data, exp_out[a]);
         end
      end
      held    = exp_out[a];
      rd_addr = AW'((a + 1) % OUT_DEPTH);
      step();
      vecs++;
      if (rd_data !== held) begin errs++; $display("FAIL readback_hold: got %h required %h", rd_data, held); end
   endtask

   task automatic test_load_gaps();
      bit ok, ok1;
      int s0 = seen_q.size();
      for (int i = 0; i < IN_DEPTH; i++) vin[i] = rnd_vec();
      start_job(2'b10);
      vecs++;
      if (pe_ce !== 3'b010) begin errs++; $display("FAIL gaps_pe_ce: got %b required 010", pe_ce); end
      load_block(1'b1, ok);
      vecs++;
      if (din_ready !== 1'b0 || !ok) begin errs++; $display("FAIL gaps_din_ready_after_last: got %b required 0", din_ready); end
      finish_job(0, 0, ok1);
      vecs++;
      if (!ok1) begin errs++; $display("FAIL gaps_timeout: got stuck required job end"); end
      vecs++;
      if (seen_q.size() - s0 !== IN_DEPTH * OUT_DEPTH) begin
         errs++;
         $display("FAIL gaps_stream_len: got %0d required %0d", seen_q.size() - s0, IN_DEPTH * OUT_DEPTH);
      end
      for (int i = 0; i < IN_DEPTH && s0 + i < seen_q.size(); i++) begin
         vecs++;
         if (seen_q[s0+i] !== vin[i]) begin errs++; $display("FAIL gaps_order[%0d]: got %h required %h", i, seen_q[s0+i], vin[i]); end
      end
   endtask

   task automatic test_wt_stall();
      bit ok, ok1, ok2;
      int bad = 0, s0;
      for (int i = 0; i < IN_DEPTH; i++) vin[i] = rnd_vec();
      start_job(2'b01);
      load_block(1'b0, ok);
      wait_wt(ok1);
      s0 = seen_q.size();
      for (int c = 0; c < 10; c++) begin
         if (wt_req !== 1'b1 || pe_en !== 1'b0) bad++;
         step();
      end
      vecs++;
      if (bad !== 0) begin errs++; $display("FAIL wt_stall_hold: got %0d bad cycles required 0", bad); end
      vecs++;
      if (seen_q.size() !== s0) begin errs++; $display("FAIL wt_stall_progress: got %0d pe_en required 0", seen_q.size() - s0); end
      finish_job(0, 0, ok2);
      vecs++;
      if (!(ok && ok1 && ok2)) begin errs++; $display("FAIL wt_stall_timeout: got stuck required job end"); end
   endtask

   task automatic test_err_mode();
      bit ok, ok1;
      start_job(2'b00);
      vecs++;
      if (err !== 1'b1 || busy !== 1'b0) begin errs++; $display("FAIL err_set: got err=%b busy=%b required err=1 busy=0", err, busy); end
      step();
      vecs++;
      if (err !== 1'b1) begin errs++; $display("FAIL err_sticky: got %b required 1", err); end
      for (int i = 0; i < IN_DEPTH; i++) vin[i] = rnd_vec();
      start_job(2'b11);
      vecs++;
      if (err !== 1'b0 || pe_ce !== 3'b100) begin errs++; $display("FAIL err_clear: got err=%b pe_ce=%b required err=0 pe_ce=100", err, pe_ce); end
      load_block(1'b0, ok);
      finish_job(2, 0, ok1);
      vecs++;
      if (!(ok && ok1)) begin errs++; $display("FAIL err_job_timeout: got stuck required job end"); end
   endtask

   task automatic test_reset_mid_run();
      bit ok, ok1, ok2;
      for (int i = 0; i < IN_DEPTH; i++) vin[i] = rnd_vec();
      start_job(2'b10);
      load_block(1'b0, ok);
      wait_wt(ok1);
      wt_ack = 1'b1;
      step();
      wt_ack = 1'b0;
      step();
      step();
      vecs++;
      if (pe_data !== vin[2] || pe_en !== 1'b1) begin errs++; $display("FAIL rstmid_j2: got %h required %h", pe_data, vin[2]); end
      #2 rst = 1'b0;
      #1;
      vecs++;
      if ({din_ready, wt_req, pe_ce, pe_en, pe_clr, busy, done, err} !== 10'd0 || pe_data !== '0 || rd_data !== '0) begin
         errs++;
         $display("FAIL rstmid_async: got ctrl=%b required all zero",
                  {din_ready, wt_req, pe_ce, pe_en, pe_clr, busy, done, err});
      end
      step();
      rst = 1'b1;
      step();
      vecs++;
      if (busy !== 1'b0 || pe_ce !== 3'b000) begin errs++; $display("FAIL rstmid_idle: got busy=%b pe_ce=%b required 0", busy, pe_ce); end
      exp_valid = 1'b0;
      for (int i = 0; i < IN_DEPTH; i++) vin[i] = rnd_vec();
      start_job(2'b01);
      load_block(1'b0, ok);
      finish_job(1, 0, ok2);
      vecs++;
      if (!(ok && ok1 && ok2)) begin errs++; $display("FAIL rstmid_timeout: got stuck required job end"); end
   endtask

   task automatic test_en_stall_wait();
      bit ok, ok1;
      int g0 = gap_q.size(), d0 = done_cnt;
      for (int i = 0; i < IN_DEPTH; i++) vin[i] = rnd_vec();
      start_job(2'b11);
      load_block(1'b0, ok);
      finish_job(1, 5, ok1);
      vecs++;
      if (!(ok && ok1)) begin errs++; $display("FAIL stall_timeout: got stuck required job end"); end
      vecs++;
      if (gap_q.size() - g0 !== OUT_DEPTH) begin
         errs++;
         $display("FAIL stall_cap_count: got %0d required %0d", gap_q.size() - g0, OUT_DEPTH);
      end else begin
         vecs++;
         if (gap_q[g0] !== PE_LAT + 1 + 5) begin errs++; $display("FAIL stall_cap_delay: got %0d required %0d", gap_q[g0], PE_LAT + 6); end
         vecs++;
         if (gap_q[g0+1] !== PE_LAT + 1) begin errs++; $display("FAIL stall_cap_next: got %0d required %0d", gap_q[g0+1], PE_LAT + 1); end
      end
      vecs++;
      if (done_cnt - d0 !== 1) begin errs++; $display("FAIL stall_done_count: got %0d required 1", done_cnt - d0); end
   endtask

   task automatic test_random_jobs();
      bit ok, ok1;
      logic [1:0] m;
      for (int n = 0; n < 3; n++) begin
         m = 2'($urandom_range(1, 3));
         for (int i = 0; i < IN_DEPTH; i++) vin[i] = rnd_vec();
         start_job(m);
         vecs++;
         if (pe_ce !== 3'(1 << (m - 1))) begin errs++; $display("FAIL rand_pe_ce: got %b required %b", pe_ce, 3'(1 << (m - 1))); end
         load_block($urandom_range(0, 1) == 1, ok);
         finish_job(int'($urandom_range(0, 3)), 0, ok1);
         vecs++;
         if (!(ok && ok1)) begin errs++; $display("FAIL rand_timeout: got stuck required job end"); end
         for (int a = 0; a < OUT_DEPTH; a++) begin
            rd_addr = AW'(a);
            rd_en   = 1'b1;
            step();
            rd_en   = 1'b0;
            vecs++;
            if (rd_data !== exp_out[a]) begin errs++; $display("FAIL rand_readback[%0d]: got %h required %h", a, rd_data, exp_out[a]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_job();
      test_readback();
      test_load_gaps();
      test_readback();
      test_wt_stall();
      test_readback();
      test_err_mode();
      test_readback();
      test_reset_mid_run();
      test_readback();
      test_en_stall_wait();
      test_readback();
      test_random_jobs();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
